i_norm_fixed_to_float: RTL
==========================

// Module: i_norm_fixed_to_float
// PURPOSE
//  Converts a signed two's-complement fixed-point word to IEEE-754 single precision.
//  It is the reverse path of the float-to-fixed converter and uses the same handshake:
//  Begin_FSM_FF starts a conversion, ACK_FF reports completion, RST_FSM_FF re-arms.
//  Normalization is iterative, one left shift per cycle, so latency depends on the data.
// PARAMETERS
//  W          32  fixed-point input width, two's complement (16..32)
//  FRAC_BITS  26  fractional bits of the input; integer bits = W-FRAC_BITS (sign included)
// PORTS
//  CLK           in   1   system clock, rising edge
//  RST_FF        in   1   asynchronous, active-low reset
//  RST_FSM_FF    in   1   synchronous, active-high FSM re-arm: returns to IDLE, clears ACK_FF
//  Begin_FSM_FF  in   1   start request, sampled in IDLE only
//  FIXED         in   W   fixed-point operand, captured on the edge that leaves IDLE
//  ACK_FF        out  1   high while in DONE; RESULT is valid
//  RESULT        out  32  packed float {sign, exp[7:0], mant[22:0]}
// BEHAVIOUR
//  Reset (RST_FF=0), from any state: FSM=IDLE, ACK_FF=0, RESULT=32'h0, internal regs=0.
//  States and timing (cycle 0 = edge at which IDLE samples Begin_FSM_FF=1):
//   IDLE : wait for Begin_FSM_FF=1; capture FIXED; go to LOAD.
//   LOAD (cycle 1): sign=FIXED[W-1]; mag=|FIXED| as a W-bit unsigned value.
//        Note -2^(W-1) gives mag=2^(W-1); no overflow.
//        Set exp=127+(W-1-FRAC_BITS). If mag==0, go to PACK with a zero flag; else go to NORM.
//   NORM : if mag[W-1]==1, go to ROUND. Else mag<<=1 and exp-=1, then stay in NORM.
//        Lasts lz+1 cycles, where lz = leading zeros of mag.
//   ROUND: kept = mag[W-2 -: 23] (the implicit 1 is dropped).
//        g = the next lower bit; s = OR of all remaining lower bits (0 if W<25).
//        Rounding is per the optional feature. A mantissa carry-out sets mant=0 and exp+=1.
//   PACK : RESULT <= zero flag ? {sign=0, 31'b0} : {sign, exp[7:0], mant}.
//   DONE : ACK_FF=1; RESULT is held. Leave only on RST_FSM_FF=1 (next state IDLE, ACK_FF=0).
//  Latency: non-zero input gives ACK_FF high at cycle lz+5; zero input gives ACK_FF high at cycle 3.
//  exp arithmetic is 9 bits wide. With W<=32 the exponent can never under- or overflow,
//   so there are no denormals and no infinity.
//  Begin_FSM_FF is ignored outside IDLE.
//  FIXED changes after capture do not affect the conversion.
//  RST_FSM_FF=1 in any state: next state IDLE, ACK_FF=0, RESULT keeps its last value.
//   It takes priority over Begin_FSM_FF in the same cycle.
//  RESULT changes only in PACK or on reset.
// CONFIGURATION
//  FX2FP_ROUND_RNE_EN defined: round to nearest, ties to even.
//   Increment when g & (s | kept[0]).
//  FX2FP_ROUND_RNE_EN undefined: truncation (no increment).
//   The ROUND state still occupies one cycle, so latency is identical in both builds.
// TESTING (W=32, FRAC_BITS=26; cycles counted as above)
//  1. FIXED=32'h04000000 (+1.0) -> RESULT=32'h3F800000; ACK_FF rises at cycle 10 (lz=5).
//  2. FIXED=32'hFA000000 (-1.5) -> RESULT=32'hBFC00000; ACK_FF at cycle 10.
//  3. FIXED=32'h00000000 -> RESULT=32'h00000000; ACK_FF at cycle 3; NORM never entered.
//  4. FIXED=32'h80000000 (-32.0) -> RESULT=32'hC2000000; ACK_FF at cycle 5.
//  5. FIXED=32'h7FFFFFFF -> with RNE: 32'h42000000 (carry into exponent);
//     without the macro: 32'h41FFFFFF.
//  6. Mid-operation aborts and re-arm:
//     a. RST_FSM_FF=1 during NORM -> IDLE next edge, ACK_FF stays 0, RESULT unchanged.
//     b. RST_FF=0 during NORM -> ACK_FF=0 and RESULT=0 immediately (asynchronous).
//     c. Begin_FSM_FF held high in DONE -> no restart until RST_FSM_FF is pulsed.

Source files
------------

// File: rtl/i_norm_fixed_to_float_if.sv
// Start/acknowledge handshake and data bus for the fixed-to-float normalizer.
// The requester drives master; the converter uses slave.
interface i_norm_fixed_to_float_if #(
   parameter int unsigned W = 32
);
   logic          RST_FSM_FF;
   logic          Begin_FSM_FF;
   logic [W-1:0]  FIXED;
   logic          ACK_FF;
   logic [31:0]   RESULT;

   modport master (
      output RST_FSM_FF,
      output Begin_FSM_FF,
      output FIXED,
      input  ACK_FF,
      input  RESULT
   );

   modport slave (
      input  RST_FSM_FF,
      input  Begin_FSM_FF,
      input  FIXED,
      output ACK_FF,
      output RESULT
   );
endinterface

// File: rtl/i_norm_fixed_to_float.sv
// Signed fixed-point to IEEE-754 single converter, normalizing one bit per cycle.
// Define FX2FP_ROUND_RNE_EN for round-to-nearest-even; default build truncates.
module i_norm_fixed_to_float #(
   parameter int unsigned W         = 32,
   parameter int unsigned FRAC_BITS = 26
) (
   input  logic                     CLK,
   input  logic                     RST_FF,
   i_norm_fixed_to_float_if.slave   bus_io
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StNorm,
      StRound,
      StPack,
      StDone
   } state_e;

   // Exponent of the MSB position before any normalizing shift.
   localparam logic [8:0] ExpInit = 9'(127 + W - 1 - FRAC_BITS);

   state_e        state_q;
   logic [W-1:0]  fixed_q;
   logic [W-1:0]  mag_q;
   logic [8:0]    exp_q;
   logic [22:0]   mant_q;
   logic          sign_q;
   logic          zero_q;
   logic          ack_q;
   logic [31:0]   result_q;

   logic [W-1:0]  mag_abs;
   logic [22:0]   kept;
   logic          round_inc;
   logic [23:0]   mant_sum;

   // -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1).
   assign mag_abs = fixed_q[W-1] ? (~fixed_q + W'(1)) : fixed_q;

`ifdef FX2FP_ROUND_RNE_EN
   // Fraction bits below the hidden one, zero-padded so narrow W still yields 23+2 bits.
   logic [W+22:0] frac_ext;
   logic          guard;
   logic          sticky;

   assign frac_ext  = {mag_q[W-2:0], 24'b0};
   assign kept      = frac_ext[W+22 -: 23];
   assign guard     = frac_ext[W-1];
   assign sticky    = |frac_ext[W-2:0];
   assign round_inc = guard & (sticky | kept[0]);
`else
   assign kept      = 23'({mag_q[W-2:0], 23'b0} >> (W - 1));
   assign round_inc = 1'b0;
`endif

   assign mant_sum = {1'b0, kept} + 24'(round_inc);

   always_ff @(posedge CLK or negedge RST_FF) begin
      if (!RST_FF) begin
         state_q  <= StIdle;
         fixed_q  <= '0;
         mag_q    <= '0;
         exp_q    <= '0;
         mant_q   <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         ack_q    <= 1'b0;
         result_q <= '0;
      end else if (bus_io.RST_FSM_FF) begin
         state_q <= StIdle;
         ack_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.Begin_FSM_FF) begin
                  fixed_q <= bus_io.FIXED;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               sign_q  <= fixed_q[W-1];
               mag_q   <= mag_abs;
               exp_q   <= ExpInit;
               zero_q  <= (fixed_q == '0);
               state_q <= (fixed_q == '0) ? StPack : StNorm;
            end
            StNorm: begin
               if (mag_q[W-1]) begin
                  state_q <= StRound;
               end else begin
                  mag_q <= mag_q << 1;
                  exp_q <= exp_q - 9'd1;
               end
            end
            StRound: begin
               // On carry-out the low 23 bits are already zero.
               mant_q <= mant_sum[22:0];
               if (mant_sum[23]) begin
                  exp_q <= exp_q + 9'd1;
               end
               state_q <= StPack;
            end
            StPack: begin
               result_q <= zero_q ? 32'h0 : {sign_q, exp_q[7:0], mant_q};
               state_q  <= StDone;
            end
            StDone: begin
               ack_q <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.ACK_FF = ack_q;
   assign bus_io.RESULT = result_q;

endmodule
